pwm_demodulator: RTL and testbench

PWM_DEMODULATOR -- requirements
Module: pwm_demodulator

---
 rtl/pwm_demodulator_if.sv | 22 ++
 rtl/pwm_demodulator.sv | 110 +++++++++++
 tb/tb_pwm_demodulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pwm_demodulator_if.sv
// Signal bundle between a PWM source and pwm_demodulator: the measured waveform
// in, and the duty/valid/period-error result out.
interface pwm_demodulator_if;
    logic       PWM_In;
    logic [7:0] Demod_Data;
    logic       Demod_Valid;
    logic       Period_Error;

    modport master (
        output PWM_In,
        input  Demod_Data,
        input  Demod_Valid,
        input  Period_Error
    );

    modport slave (
        input  PWM_In,
        output Demod_Data,
        output Demod_Valid,
        output Period_Error
    );
endinterface

// File: rtl/pwm_demodulator.sv
// Measures PWM high time per period (nominal 256 clocks). Optional macro
// PWM_DEMOD_PERIOD_CHECK_EN builds the period comparator behind Period_Error.
module pwm_demodulator (
    input  logic              Demod_Clock,
    input  logic              Demod_Reset,
    pwm_demodulator_if.slave  bus
);
    localparam logic [8:0] PERIOD_FULL = 9'd256;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    // [0] first synchronizer flop, [1] sampled signal s, [2] s_prev
    logic [2:0] sync_reg;
    logic [8:0] p_reg, p_next;
    logic [8:0] h_reg, h_next;
    logic [7:0] data_reg, data_next;
    logic       valid_reg, valid_next;

    logic       s_cur;
    logic       rise;
    logic       timeout;
    logic       edge_report;
    logic       timeout_report;
    logic [8:0] p_inc;
    logic [8:0] h_inc;
    logic [7:0] h_sat;

    assign s_cur   = sync_reg[1];
    assign rise    = sync_reg[1] & ~sync_reg[2];
    assign timeout = (p_reg == PERIOD_FULL);

    // Counters stick at 256; bit 8 set means exactly 256.
    assign p_inc = p_reg[8] ? p_reg : p_reg + 9'd1;
    assign h_inc = h_reg[8] ? h_reg : h_reg + 9'd1;
    assign h_sat = h_reg[8] ? 8'hFF : h_reg[7:0];

    always_ff @(posedge Demod_Clock or posedge Demod_Reset) begin
        if (Demod_Reset) begin
            sync_reg  <= 3'b000;
            state_reg <= IDLE;
            p_reg     <= 9'd0;
            h_reg     <= 9'd0;
            data_reg  <= 8'd0;
            valid_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[1:0], bus.PWM_In};
            state_reg <= state_next;
            p_reg     <= p_next;
            h_reg     <= h_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        p_next         = p_inc;
        h_next         = s_cur ? h_inc : h_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        edge_report    = 1'b0;
        timeout_report = 1'b0;

        // A rising edge always wins over a coincident timeout.
        if (rise) begin
            p_next     = 9'd1;
            h_next     = 9'd1;
            state_next = MEASURE;
            if (state_reg == MEASURE) begin
                edge_report = 1'b1;
                data_next   = h_sat;
                valid_next  = 1'b1;
            end
        end else if (timeout) begin
            timeout_report = 1'b1;
            p_next         = 9'd0;
            h_next         = 9'd0;
            data_next      = h_sat;
            valid_next     = 1'b1;
            state_next     = MEASURE;
        end
    end

`ifdef PWM_DEMOD_PERIOD_CHECK_EN
    logic err_reg;

    always_ff @(posedge Demod_Clock or posedge Demod_Reset) begin
        if (Demod_Reset) begin
            err_reg <= 1'b0;
        end else if (edge_report) begin
            err_reg <= (p_reg != PERIOD_FULL);
        end else if (timeout_report) begin
            err_reg <= 1'b0;
        end
    end

    assign bus.Period_Error = err_reg;
`else
    logic unused_report;
    assign unused_report    = edge_report ^ timeout_report;
    assign bus.Period_Error = 1'b0;
`endif

    assign bus.Demod_Data  = data_reg;
    assign bus.Demod_Valid = valid_reg;
endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator: fixed PWM patterns, hand-computed
// expected duty, period flag and pulse timing.
module tb_pwm_demodulator;
    logic clk;
    logic rst;
    int   cyc;
    int   base;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       err;
    } ev_t;
    ev_t evq[$];

`ifdef PWM_DEMOD_PERIOD_CHECK_EN
    localparam logic PE_200 = 1'b1;
`else
    localparam logic PE_200 = 1'b0;
`endif

    pwm_demodulator_if bus ();

    pwm_demodulator dut (
        .Demod_Clock (clk),
        .Demod_Reset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Demod_Valid === 1'b1)
            evq.push_back('{cyc, bus.Demod_Data, bus.Period_Error});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Holds PWM_In at lvl through reset; returns #1 after the edge preceding E1.
    task automatic do_reset(input logic lvl);
        bus.PWM_In = lvl;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        evq.delete();
        base = cyc;
    endtask

    task automatic run_periods(input int hi, input int per, input int count);
        for (int k = 0; k < count; k++) begin
            for (int i = 0; i < per; i++) begin
                bus.PWM_In = (i < hi);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // first < 0 skips the timing of the first pulse; spacing 0 skips intervals.
    task automatic check_events(input string tag, input int n, input logic [7:0] d,
                                input logic e, input int first, input int spacing);
        check({tag, " count"}, evq.size(), n);
        for (int i = 0; i < evq.size() && i < n; i++) begin
            check($sformatf("%s data[%0d]", tag, i), evq[i].data, d);
            check($sformatf("%s err[%0d]", tag, i), evq[i].err, e);
            if (i == 0 && first >= 0)
                check({tag, " first at"}, evq[0].at - base, first);
            if (i > 0 && spacing > 0)
                check($sformatf("%s gap[%0d]", tag, i), evq[i].at - evq[i-1].at, spacing);
        end
    endtask

    int early;

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        bus.PWM_In = 1'b0;
        rst = 1'b1;
        #2;
        check("reset data", bus.Demod_Data, 0);
        check("reset valid", bus.Demod_Valid, 0);
        check("reset err", bus.Period_Error, 0);

        // 256/64: first edge silent, then 64 every 256 clocks, 3 clocks latency
        do_reset(1'b0);
        run_periods(64, 256, 4);
        check_events("duty64", 3, 8'd64, 1'b0, 259, 256);

        // 256/255: one-clock low still measures 255
        do_reset(1'b0);
        run_periods(255, 256, 4);
        check_events("duty255", 3, 8'd255, 1'b0, 259, 256);

        // 200/50: short period flagged only when the comparator is built
        do_reset(1'b0);
        run_periods(50, 200, 4);
        check_events("per200", 3, 8'd50, PE_200, 203, 200);

        // constant low: timeout reports 0
        do_reset(1'b0);
        run_cycles(600);
        check_events("const0", 2, 8'd0, 1'b0, -1, 0);

        // high at reset release: IDLE edge silent, timeouts report 255
        do_reset(1'b1);
        run_cycles(600);
        check_events("const1", 2, 8'd255, 1'b0, -1, 0);

        // asynchronous reset 100 clocks into a window with duty 128
        do_reset(1'b0);
        run_periods(128, 256, 1);
        for (int i = 0; i < 100; i++) begin
            bus.PWM_In = 1'b1;
            @(posedge clk);
            #1;
        end
        check_events("pre-rst", 1, 8'd128, 1'b0, 259, 0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst data", bus.Demod_Data, 0);
        check("midrst valid", bus.Demod_Valid, 0);
        check("midrst err", bus.Period_Error, 0);
        bus.PWM_In = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        evq.delete();
        base = cyc;
        run_periods(128, 256, 3);
        check_events("post-rst", 2, 8'd128, 1'b0, 259, 256);

        // edge processed in the same cycle P hits 256 while IDLE: edge wins, no pulse
        do_reset(1'b0);
        run_cycles(254);
        bus.PWM_In = 1'b1;
        run_cycles(346);
        early = 0;
        foreach (evq[i]) if (evq[i].at - base < 400) early++;
        check("coincide early pulses", early, 0);
        check_events("coincide", 1, 8'd255, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
